layer_output_serializer: RTL
============================

Name: layer_output_serializer

Overview:
- Sits between two fully connected layers.
- Captures the parallel outputs of every neuron in one layer in the cycle they assert outvalid, then replays them one element per clock as the myinput/myinputValid stream for the next layer's neurons.
- Provides one-vector double buffering, so a new layer result can arrive while the previous one is still being streamed.
- Flags a sticky overflow if a vector arrives with both buffers full.

Parameters:
- numNeuron, 30, number of neurons in the producing layer = elements per vector = numWeight of next layer
- dataWidth, 16, width of one neuron output and of the serial output

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- layer_out  input  numNeuron*dataWidth  concatenated neuron outputs; neuron n in bits [n*dataWidth +: dataWidth]
- layer_outvalid  input  1  single-cycle pulse; all neuron outvalids of the layer are coincident; this is neuron 0's outvalid
- data_out  output  dataWidth  current serial element, drives next layer myinput
- data_out_valid  output  1  drives next layer myinputValid
- data_out_last  output  1  high with the final element (index numNeuron-1) of each vector
- busy  output  1  high while a vector is streaming or pending
- overflow  output  1  sticky error, a vector was dropped

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values: data_out=0, data_out_valid=0, data_out_last=0, busy=0, overflow=0. Both buffers are empty and the element counter is 0.
- Reset mid-stream aborts the current and pending vectors. data_out_valid is 0 in the cycle after the reset edge; no partial resumption.
- Internal storage:
  - shift buffer (active vector) plus element counter 0..numNeuron-1.
  - hold buffer (pending vector) plus pending flag.
- States:
  - IDLE: nothing active.
  - STREAM: active vector being emitted.
  - Counter width is $clog2(numNeuron), minimum 1.
- Latency: layer_outvalid sampled high at edge k while IDLE means element 0 is on data_out with data_out_valid=1 after edge k+1. Element i is presented after edge k+1+i.
- data_out_valid stays high for exactly numNeuron consecutive cycles per vector. Elements go out in neuron order 0..numNeuron-1. There is no backpressure.
- Last-element edge: the edge that retires element numNeuron-1.
  - If the pending flag is set, the hold buffer moves to the shift buffer and element 0 of it is presented in the next cycle (zero-gap back-to-back). The pending flag clears.
  - Else, if layer_outvalid is high at this same edge, the new vector goes directly to the shift buffer with zero gap.
  - Else the block returns to IDLE and data_out_valid=0.
- layer_outvalid during STREAM, not at the last-element edge:
  - If hold is empty, capture into hold and set pending.
  - If hold is full, drop the new vector and set overflow=1. The current and pending vectors are unaffected.
- layer_outvalid at the last-element edge with pending set: pending moves to shift, the new vector moves to hold, pending stays set, no overflow.
- overflow clears only on rst.
- busy = STREAM or pending, registered with the other outputs.
- data_out holds its last value when data_out_valid=0. Downstream must qualify it with data_out_valid.
- data_out is a pure copy of the neuron output: no arithmetic, sign or width change.
- layer_out is sampled only on the edge where layer_outvalid=1; it is don't-care otherwise.

Test Plan:
- numNeuron=4, dataWidth=16. Pulse layer_outvalid with layer_out={16'h0004,16'h0003,16'h0002,16'h0001} from IDLE.
  - Expect data_out 0001,0002,0003,0004 on 4 consecutive cycles starting 1 cycle after the pulse.
  - Expect data_out_last only with 0004, then data_out_valid=0 and busy=0.
- Second vector {8,7,6,5} pulsed on the 2nd streaming cycle of the first.
  - Expect 1,2,3,4,5,6,7,8 with data_out_valid continuously high for 8 cycles.
  - Expect data_out_last on 4 and 8, and overflow=0.
- Second vector pulsed exactly at the last-element edge of the first.
  - Expect a zero-gap stream of 8 elements and the pending flag never used (busy drops right after element 8).
- Three vectors A, B, C, with B and C pulsed during the streaming of A, before its last edge.
  - Expect C dropped and overflow=1 (sticky).
  - Expect the output to be exactly A then B (8 elements).
- Assert rst on the 3rd element of a vector with one pending.
  - Expect data_out_valid=0, busy=0, overflow=0 after the reset edge, and no further output.
  - A new pulse after reset streams normally with 1-cycle latency.
- Signed values {16'h8000,16'h7FFF,16'hFFFF,16'h0000}: expect the exact bit patterns reproduced in order.

Source files
------------

// File: rtl/layer_output_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : layer_output_serializer
//  Description : Captures one layer's parallel neuron outputs and replays them
//                one element per clock, with a one-vector hold buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
module layer_output_serializer #(
  parameter int numNeuron = 30,
  parameter int dataWidth = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [numNeuron*dataWidth-1:0] layer_out,
  input  logic                           layer_outvalid,
  output logic [dataWidth-1:0]           data_out,
  output logic                           data_out_valid,
  output logic                           data_out_last,
  output logic                           busy,
  output logic                           overflow
);

  localparam int                 c_VEC_W  = numNeuron * dataWidth;
  localparam int                 c_CNT_W  = (numNeuron > 1) ? $clog2(numNeuron) : 1;
  localparam logic [c_CNT_W-1:0] c_LAST   = c_CNT_W'(numNeuron - 1);
  localparam logic [c_CNT_W-1:0] c_ONE    = c_CNT_W'(1);
  localparam logic               c_SINGLE = (numNeuron == 1);

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_STREAM = 1'b1
  } state_t;

  state_t             r_state;
  logic [c_VEC_W-1:0] r_shift;
  logic [c_VEC_W-1:0] r_hold;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_pending;

  logic               w_last_edge;
  logic [c_CNT_W-1:0] w_cnt_next;
  logic [c_VEC_W-1:0] w_load_vec;

  // In STREAM with data_out_valid low the block is in its priming cycle:
  // element 0 has been captured but not yet presented.
  assign w_last_edge = data_out_valid && (r_cnt == c_LAST);
  assign w_cnt_next  = data_out_valid ? (r_cnt + c_ONE) : '0;
  assign w_load_vec  = r_pending ? r_hold : layer_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_shift        <= '0;
      r_hold         <= '0;
      r_cnt          <= '0;
      r_pending      <= 1'b0;
      data_out       <= '0;
      data_out_valid <= 1'b0;
      data_out_last  <= 1'b0;
      busy           <= 1'b0;
      overflow       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          data_out_valid <= 1'b0;
          data_out_last  <= 1'b0;
          busy           <= layer_outvalid;
          if (layer_outvalid) begin
            r_shift <= layer_out;
            r_cnt   <= '0;
            r_state <= S_STREAM;
          end
        end

        S_STREAM: begin
          busy <= 1'b1;
          if (!w_last_edge) begin
            data_out       <= r_shift[dataWidth-1:0];
            r_shift        <= r_shift >> dataWidth;
            r_cnt          <= w_cnt_next;
            data_out_valid <= 1'b1;
            data_out_last  <= (w_cnt_next == c_LAST);
            if (layer_outvalid) begin
              if (r_pending) begin
                overflow <= 1'b1;
              end else begin
                r_hold    <= layer_out;
                r_pending <= 1'b1;
              end
            end
          end else if (r_pending || layer_outvalid) begin
            // Zero-gap handover: element 0 of the next vector goes straight out.
            data_out       <= w_load_vec[dataWidth-1:0];
            r_shift        <= w_load_vec >> dataWidth;
            r_cnt          <= '0;
            data_out_valid <= 1'b1;
            data_out_last  <= c_SINGLE;
            r_pending      <= r_pending && layer_outvalid;
            if (r_pending && layer_outvalid) begin
              r_hold <= layer_out;
            end
          end else begin
            r_state        <= S_IDLE;
            data_out_valid <= 1'b0;
            data_out_last  <= 1'b0;
            busy           <= 1'b0;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
